// File: rtl/ddp_hs_pkg.sv
// Shared 4-phase handshake encodings and sizing helpers for the
// data-driven pipeline join/FIFO blocks.
package ddp_hs_pkg;

  typedef enum logic {
    J_IDLE = 1'b0,
    J_ACK  = 1'b1
  } join_state_e;

  typedef enum logic [1:0] {
    O_IDLE = 2'd0,
    O_SEND = 2'd1,
    O_REL  = 2'd2
  } out_state_e;

  // Occupancy counter width able to hold 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/cj_join_fifo_if.sv
// Handshake bundle for cj_join_fifo: N_IN joined input channels, one
// buffered output channel, firing controls and status pulses.
interface cj_join_fifo_if #(
  parameter int N_IN  = 2,
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  import ddp_hs_pkg::*;

  localparam int CNT_W = cnt_w(DEPTH);

  logic                    z;
  logic                    g;
  logic [N_IN-1:0]         Send_in;
  logic [N_IN*WIDTH-1:0]   data_in;
  logic [N_IN-1:0]         Ack_out;
  logic                    Send_out;
  logic [N_IN*WIDTH-1:0]   data_out;
  logic                    Ack_in;
  logic                    cp;
  logic                    dp;
  logic [CNT_W-1:0]        count;

  // Environment side: drives requests/controls, observes acks and status.
  modport master (
    output z, g, Send_in, data_in, Ack_in,
    input  Ack_out, Send_out, data_out, cp, dp, count
  );

  // Join controller side.
  modport slave (
    input  z, g, Send_in, data_in, Ack_in,
    output Ack_out, Send_out, data_out, cp, dp, count
  );

endinterface

// File: rtl/ddp_sync_fifo.sv
// Single-clock FIFO of joined tokens with asynchronous clear; storage is
// zeroed on reset so the head never shows X.
module ddp_sync_fifo
  import ddp_hs_pkg::*;
#(
  parameter int WIDTH_T = 16,
  parameter int DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       MR,
  input  logic                       push,
  input  logic [WIDTH_T-1:0]         push_data,
  input  logic                       pop,
  output logic [cnt_w(DEPTH)-1:0]    count,
  output logic [WIDTH_T-1:0]         head
);

  localparam int CNT_W = cnt_w(DEPTH);
  localparam int AW    = $clog2(DEPTH);

  logic [WIDTH_T-1:0] mem_q [DEPTH];
  logic [WIDTH_T-1:0] mem_d [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_push, do_pop;

  // Guards keep the count coherent even if a caller misbehaves.
  assign do_push = push && (count_q != CNT_W'(DEPTH));
  assign do_pop  = pop  && (count_q != '0);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk or posedge MR) begin
    if (MR) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/cj_join_fifo.sv
// Clocked CJ join: fires when every input channel requests and z allows,
// stores (g=1) or discards (g=0) the joined token, and drains it 4-phase.
module cj_join_fifo
  import ddp_hs_pkg::*;
#(
  parameter int N_IN  = 2,
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           MR,
  cj_join_fifo_if.slave  bus
);

  localparam int CNT_W = cnt_w(DEPTH);
  localparam int DW    = N_IN * WIDTH;

  join_state_e      j_state_q, j_state_d;
  out_state_e       o_state_q, o_state_d;
  logic [N_IN-1:0]  ack_out_q, ack_out_d;
  logic             send_out_q, send_out_d;
  logic             cp_q, cp_d;
  logic             dp_q, dp_d;
  logic             fire, push, pop, room;
  logic [CNT_W-1:0] count;
  logic [DW-1:0]    head;

  // Space is judged on the pre-edge count; a same-edge pop does not help.
  assign room = count < CNT_W'(DEPTH);
  assign fire = (j_state_q == J_IDLE) && (&bus.Send_in) && (ack_out_q == '0)
                && bus.z && (bus.g ? room : 1'b1);

  always_comb begin
    j_state_d = j_state_q;
    ack_out_d = ack_out_q;
    cp_d      = 1'b0;
    dp_d      = 1'b0;
    push      = 1'b0;
    case (j_state_q)
      J_IDLE: begin
        if (fire) begin
          ack_out_d = '1;
          cp_d      = bus.g;
          dp_d      = ~bus.g;
          push      = bus.g;
          j_state_d = J_ACK;
        end
      end
      J_ACK: begin
        // Each channel releases on its own once its request is seen low.
        ack_out_d = ack_out_q & bus.Send_in;
        if (ack_out_q == '0) j_state_d = J_IDLE;
      end
      default: j_state_d = J_IDLE;
    endcase
  end

  always_comb begin
    o_state_d  = o_state_q;
    send_out_d = send_out_q;
    pop        = 1'b0;
    case (o_state_q)
      O_IDLE: begin
        if ((count != '0) && !bus.Ack_in) begin
          send_out_d = 1'b1;
          o_state_d  = O_SEND;
        end
      end
      O_SEND: begin
        if (bus.Ack_in) begin
          pop        = 1'b1;
          send_out_d = 1'b0;
          o_state_d  = O_REL;
        end
      end
      O_REL: begin
        if (!bus.Ack_in) o_state_d = O_IDLE;
      end
      default: begin
        send_out_d = 1'b0;
        o_state_d  = O_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge MR) begin
    if (MR) begin
      j_state_q  <= J_IDLE;
      o_state_q  <= O_IDLE;
      ack_out_q  <= '0;
      send_out_q <= 1'b0;
      cp_q       <= 1'b0;
      dp_q       <= 1'b0;
    end else begin
      j_state_q  <= j_state_d;
      o_state_q  <= o_state_d;
      ack_out_q  <= ack_out_d;
      send_out_q <= send_out_d;
      cp_q       <= cp_d;
      dp_q       <= dp_d;
    end
  end

  ddp_sync_fifo #(
    .WIDTH_T (DW),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .MR        (MR),
    .push      (push),
    .push_data (bus.data_in),
    .pop       (pop),
    .count     (count),
    .head      (head)
  );

  assign bus.Ack_out  = ack_out_q;
  assign bus.Send_out = send_out_q;
  assign bus.data_out = head;
  assign bus.cp       = cp_q;
  assign bus.dp       = dp_q;
  assign bus.count    = count;

endmodule

// File: tb/tb_cj_join_fifo.sv
// Directed bench for cj_join_fifo (N_IN=2, WIDTH=8, DEPTH=4) with
// hand-computed expectations per cycle.
module tb_cj_join_fifo;

  logic clk = 1'b0;
  logic MR;
  int   nvec = 0;
  int   nmis = 0;

  always #5 clk = ~clk;

  cj_join_fifo_if #(.N_IN(2), .WIDTH(8), .DEPTH(4)) bus ();

  cj_join_fifo #(.N_IN(2), .WIDTH(8), .DEPTH(4)) dut (
    .clk (clk),
    .MR  (MR),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Fire one stored token and complete its input handshake (3 edges).
  task automatic fire_tok(input logic [15:0] d);
    bus.Send_in = 2'b11;
    bus.data_in = d;
    step();
    bus.Send_in = 2'b00;
    step();
    step();
  endtask

  task automatic drain_one(input string tag, input logic [15:0] d);
    for (int i = 0; i < 12 && bus.Send_out !== 1'b1; i++) step();
    chk({tag, "_so"}, bus.Send_out, 1);
    chk({tag, "_data"}, bus.data_out, d);
    bus.Ack_in = 1'b1;
    step();
    chk({tag, "_pop"}, bus.Send_out, 0);
    bus.Ack_in = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    MR = 1'b1;
    bus.z = 1'b0; bus.g = 1'b0; bus.Send_in = '0; bus.data_in = '0; bus.Ack_in = 1'b0;
    #2;
    chk("rst_ack", bus.Ack_out, 0);
    chk("rst_so", bus.Send_out, 0);
    chk("rst_cp", bus.cp, 0);
    chk("rst_dp", bus.dp, 0);
    chk("rst_cnt", bus.count, 0);
    chk("rst_head", bus.data_out, 0);
    step(); step();
    MR = 1'b0;
    step();

    // Basic fire, store, drain
    bus.z = 1'b1; bus.g = 1'b1; bus.Send_in = 2'b11; bus.data_in = 16'hA53C;
    step();
    chk("t1_ack", bus.Ack_out, 2'b11);
    chk("t1_cp", bus.cp, 1);
    chk("t1_cnt", bus.count, 1);
    chk("t1_so_early", bus.Send_out, 0);
    bus.Send_in = 2'b00;
    step();
    chk("t1_ack_clr", bus.Ack_out, 0);
    chk("t1_cp_off", bus.cp, 0);
    chk("t1_so", bus.Send_out, 1);
    chk("t1_data", bus.data_out, 16'hA53C);
    bus.Ack_in = 1'b1;
    step();
    chk("t1_so_drop", bus.Send_out, 0);
    chk("t1_cnt0", bus.count, 0);
    bus.Ack_in = 1'b0;
    step(); step();

    // Staggered request arrival and release
    bus.Send_in = 2'b10; bus.data_in = 16'h1122;
    repeat (3) begin
      step();
      chk("t2_wait", {bus.Ack_out, bus.cp}, 0);
    end
    bus.Send_in = 2'b11;
    step();
    chk("t2_ack", bus.Ack_out, 2'b11);
    chk("t2_cp", bus.cp, 1);
    bus.Send_in = 2'b01;
    step();
    chk("t2_ack_hi_clr", bus.Ack_out, 2'b01);
    bus.Send_in = 2'b00;
    step();
    chk("t2_ack_lo_clr", bus.Ack_out, 2'b00);
    drain_one("t2", 16'h1122);

    // z holds off firing
    bus.z = 1'b0; bus.data_in = 16'h5AC3; bus.Send_in = 2'b11;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t3_hold", {bus.Ack_out, bus.cp}, 0);
    end
    bus.z = 1'b1;
    step();
    chk("t3_ack", bus.Ack_out, 2'b11);
    chk("t3_cp", bus.cp, 1);
    bus.Send_in = 2'b00;
    step();
    drain_one("t3", 16'h5AC3);
    step();

    // g=0 discards
    bus.g = 1'b0; bus.data_in = 16'hFFFF; bus.Send_in = 2'b11;
    step();
    chk("t4_dp", bus.dp, 1);
    chk("t4_cp", bus.cp, 0);
    chk("t4_ack", bus.Ack_out, 2'b11);
    chk("t4_cnt", bus.count, 0);
    bus.Send_in = 2'b00;
    step();
    chk("t4_dp_off", bus.dp, 0);
    chk("t4_so", bus.Send_out, 0);
    step();
    chk("t4_so_late", bus.Send_out, 0);
    chk("t4_cnt_late", bus.count, 0);
    bus.g = 1'b1;

    // Fill to DEPTH, fifth join stalls until the first pop
    fire_tok(16'h0101);
    fire_tok(16'h0202);
    fire_tok(16'h0303);
    fire_tok(16'h0404);
    chk("t5_full", bus.count, 4);
    bus.Send_in = 2'b11; bus.data_in = 16'h0505;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_stall", {bus.Ack_out, bus.cp}, 0);
      chk("t5_stall_cnt", bus.count, 4);
    end
    chk("t5_head", bus.data_out, 16'h0101);
    chk("t5_so", bus.Send_out, 1);
    bus.Ack_in = 1'b1;
    step();
    chk("t5_pop_ack", bus.Ack_out, 0);
    chk("t5_pop_cnt", bus.count, 3);
    bus.Ack_in = 1'b0;
    step();
    chk("t5_fire", bus.Ack_out, 2'b11);
    chk("t5_fire_cnt", bus.count, 4);
    bus.Send_in = 2'b00;
    step();
    drain_one("t5_2", 16'h0202);
    drain_one("t5_3", 16'h0303);
    drain_one("t5_4", 16'h0404);
    drain_one("t5_5", 16'h0505);
    chk("t5_empty", bus.count, 0);
    step(); step();

    // Asynchronous reset mid-handshake
    fire_tok(16'h0606);
    bus.Send_in = 2'b11; bus.data_in = 16'h0707;
    step();
    chk("t6_pre_cnt", bus.count, 2);
    chk("t6_pre_so", bus.Send_out, 1);
    chk("t6_pre_ack", bus.Ack_out, 2'b11);
    #2 MR = 1'b1;
    #1;
    chk("t6_ack", bus.Ack_out, 0);
    chk("t6_so", bus.Send_out, 0);
    chk("t6_cnt", bus.count, 0);
    chk("t6_cp", bus.cp, 0);
    chk("t6_dp", bus.dp, 0);
    chk("t6_head", bus.data_out, 0);
    bus.Send_in = 2'b00;
    step();
    MR = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t6_idle", {bus.Send_out, bus.Ack_out}, 0);
      chk("t6_idle_cnt", bus.count, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
